// File: rtl/imu_differentiator.sv
// imu_differentiator
//   Recovers acceleration from successive velocity samples: a(k) = (v(k) - v(k-1)) / dt.
//   All data words are signed Q(WP-FRAC).FRAC. The division is restoring and bit-serial,
//   WP+FRAC+1 cycles per result. The first sample after reset only primes v_prev.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   sample valid
//   in_ready   block can accept a sample (registered, high only in IDLE)
//   v_in       velocity v(k)
//   dt         sample interval
//   out_valid  result valid (registered, high only in DONE)
//   out_ready  consumer accepts result
//   a_out      acceleration
//   out_sat    result was clamped (constant 0 unless IMU_DIFF_SAT_EN)
//   out_err    dt <= 0, a_out forced to 0
//
// Build option
//   IMU_DIFF_SAT_EN  defined: clamp out-of-range quotients and flag out_sat.
//                    undefined: keep the low WP bits of the quotient (wrap).

module imu_differentiator #(
   parameter int unsigned WP   = 32,
   parameter int unsigned FRAC = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [WP-1:0] v_in,
   input  logic [WP-1:0] dt,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [WP-1:0] a_out,
   output logic          out_sat,
   output logic          out_err
);

   localparam int unsigned N  = WP + FRAC + 1;
   localparam int unsigned CW = $clog2(N);

   typedef enum logic [1:0] {StIdle, StPrep, StDiv, StDone} state_e;

   state_e        state_q, state_d;
   logic          primed_q, primed_d;
   logic [WP-1:0] v_prev_q, v_prev_d;
   logic [WP-1:0] v_cur_q, v_cur_d;
   logic [WP-1:0] dt_q, dt_d;
   // Dividend bits leave at the top while quotient bits enter at the bottom.
   logic [N-1:0]  dq_q, dq_d;
   // Remainder stays below dt (< 2^(WP-1)), so WP bits are plenty.
   logic [WP-1:0] rem_q, rem_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          neg_q, neg_d;
   logic [WP-1:0] a_q, a_d;
   logic          err_q, err_d;
`ifdef IMU_DIFF_SAT_EN
   logic          sat_q, sat_d;
   localparam logic [N-1:0] LimPos = {{(N-WP+1){1'b0}}, {(WP-1){1'b1}}};
   localparam logic [N-1:0] LimNeg = LimPos + N'(1);
   logic          fits;
`endif

   // Difference at WP+1 bits cannot overflow.
   logic [WP:0]   dv;
   logic [WP:0]   dv_mag;
   logic          dt_nonpos;
   logic [WP:0]   rem_sh;
   logic [WP:0]   rem_sub;
   logic          ge;
   logic [N-1:0]  dq_nx;
   logic [WP-1:0] q_wrap;
   logic          last_iter;

   always_comb begin
      dv        = {v_cur_q[WP-1], v_cur_q} - {v_prev_q[WP-1], v_prev_q};
      dv_mag    = dv[WP] ? (~dv + (WP+1)'(1)) : dv;
      dt_nonpos = dt_q[WP-1] || (dt_q == '0);
      rem_sh    = {rem_q, dq_q[N-1]};
      rem_sub   = rem_sh - {1'b0, dt_q};
      ge        = (rem_sh >= {1'b0, dt_q});
      dq_nx     = {dq_q[N-2:0], ge};
      // Low WP bits of the negated magnitude equal the low bits of the signed quotient.
      q_wrap    = neg_q ? (~dq_nx[WP-1:0] + WP'(1)) : dq_nx[WP-1:0];
      last_iter = (cnt_q == CW'(N - 1));
`ifdef IMU_DIFF_SAT_EN
      fits      = neg_q ? (dq_nx <= LimNeg) : (dq_nx <= LimPos);
`endif
   end

   always_comb begin
      state_d  = state_q;
      primed_d = primed_q;
      v_prev_d = v_prev_q;
      v_cur_d  = v_cur_q;
      dt_d     = dt_q;
      dq_d     = dq_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      a_d      = a_q;
      err_d    = err_q;
`ifdef IMU_DIFF_SAT_EN
      sat_d    = sat_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               if (!primed_q) begin
                  v_prev_d = v_in;
                  primed_d = 1'b1;
               end else begin
                  v_cur_d = v_in;
                  dt_d    = dt;
                  state_d = StPrep;
               end
            end
         end
         StPrep: begin
            v_prev_d = v_cur_q;
            if (dt_nonpos) begin
               a_d     = '0;
               err_d   = 1'b1;
`ifdef IMU_DIFF_SAT_EN
               sat_d   = 1'b0;
`endif
               state_d = StDone;
            end else begin
               dq_d    = {dv_mag, {FRAC{1'b0}}};
               rem_d   = '0;
               neg_d   = dv[WP];
               cnt_d   = '0;
               state_d = StDiv;
            end
         end
         StDiv: begin
            dq_d  = dq_nx;
            rem_d = WP'(ge ? rem_sub : rem_sh);
            cnt_d = cnt_q + CW'(1);
            if (last_iter) begin
`ifdef IMU_DIFF_SAT_EN
               if (fits) begin
                  a_d   = q_wrap;
                  sat_d = 1'b0;
               end else begin
                  a_d   = neg_q ? {1'b1, {(WP-1){1'b0}}} : {1'b0, {(WP-1){1'b1}}};
                  sat_d = 1'b1;
               end
`else
               a_d = q_wrap;
`endif
               err_d   = 1'b0;
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               err_d   = 1'b0;
`ifdef IMU_DIFF_SAT_EN
               sat_d   = 1'b0;
`endif
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         primed_q <= 1'b0;
         v_prev_q <= '0;
         v_cur_q  <= '0;
         dt_q     <= '0;
         dq_q     <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         a_q      <= '0;
         err_q    <= 1'b0;
`ifdef IMU_DIFF_SAT_EN
         sat_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         primed_q <= primed_d;
         v_prev_q <= v_prev_d;
         v_cur_q  <= v_cur_d;
         dt_q     <= dt_d;
         dq_q     <= dq_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         a_q      <= a_d;
         err_q    <= err_d;
`ifdef IMU_DIFF_SAT_EN
         sat_q    <= sat_d;
`endif
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign a_out     = a_q;
   assign out_err   = err_q;
`ifdef IMU_DIFF_SAT_EN
   assign out_sat   = sat_q;
`else
   assign out_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_imu_differentiator.sv
// Randomized self-checking bench for imu_differentiator against a plain-arithmetic model.
module tb_imu_differentiator;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] v_in;
   logic [31:0] dt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] a_out;
   logic        out_sat;
   logic        out_err;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference state
   bit          m_primed = 1'b0;
   logic [31:0] m_prev   = '0;

   imu_differentiator #(
      .WP   (32),
      .FRAC (16)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .v_in      (v_in),
      .dt        (dt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .a_out     (a_out),
      .out_sat   (out_sat),
      .out_err   (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // a = (v - v_prev) * 2^16 / dt, truncated toward zero, in 64-bit arithmetic.
   function automatic void model(input logic [31:0] v, input logic [31:0] d,
                                 output logic [31:0] a, output logic sat, output logic err);
      longint dv;
      longint mag;
      longint q;
      longint sq;
      dv  = longint'($signed(v)) - longint'($signed(m_prev));
      sat = 1'b0;
      err = 1'b0;
      a   = '0;
      if ($signed(d) <= 0) begin
         err = 1'b1;
         return;
      end
      mag = ((dv < 0) ? -dv : dv) * 65536;
      q   = mag / longint'(d);
      sq  = (dv < 0) ? -q : q;
      if (sq > 64'sh0000_0000_7FFF_FFFF || sq < -64'sh0000_0000_8000_0000) begin
`ifdef IMU_DIFF_SAT_EN
         a   = (dv < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
         sat = 1'b1;
`else
         a   = sq[31:0];
`endif
      end else begin
         a = sq[31:0];
      end
   endfunction

   // Sends one sample and, for non-priming samples, collects and checks the result.
   // bp: cycles of backpressure after out_valid; early: out_ready raised before out_valid.
   task automatic do_sample(input logic [31:0] v, input logic [31:0] d, input int bp,
                            input bit early, output logic [31:0] got_a);
      logic [31:0] ea;
      logic        es;
      logic        ee;
      int          lat;
      int          wt;
      got_a = '0;
      wt = 0;
      while (!in_ready && wt < 200) begin
         @(posedge clk);
         @(negedge clk);
         wt++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", 64'(in_ready), 64'd1);
         return;
      end
      in_valid = 1'b1;
      v_in     = v;
      dt       = d;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      v_in     = $urandom;
      dt       = $urandom;
      if (!m_primed) begin
         m_primed = 1'b1;
         m_prev   = v;
         check("prime_in_ready", 64'(in_ready), 64'd1);
         check("prime_no_valid", 64'(out_valid), 64'd0);
         return;
      end
      model(v, d, ea, es, ee);
      m_prev = v;
      check("busy_in_ready", 64'(in_ready), 64'd0);
      if (early) out_ready = 1'b1;
      lat = 1;
      while (!out_valid && lat < 120) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      check("latency", 64'(lat), ee ? 64'd2 : 64'd51);
      if (!out_valid) begin
         out_ready = 1'b0;
         return;
      end
      got_a = a_out;
      check("a_out", 64'(a_out), 64'(ea));
      check("out_sat", 64'(out_sat), 64'(es));
      check("out_err", 64'(out_err), 64'(ee));
      if (!early) begin
         for (int i = 0; i < bp; i++) begin
            in_valid = 1'b1;
            v_in     = $urandom;
            dt       = 32'h0001_0000;
            @(posedge clk);
            @(negedge clk);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_a_out", 64'(a_out), 64'(ea));
            check("bp_flags", 64'({out_sat, out_err}), 64'({es, ee}));
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("post_hs_valid", 64'(out_valid), 64'd0);
      check("post_hs_in_ready", 64'(in_ready), 64'd1);
      check("post_hs_flags", 64'({out_sat, out_err}), 64'd0);
   endtask

   initial begin
      logic [31:0] ga;
      logic [31:0] rv;
      logic [31:0] rd;
      int          mode;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      v_in      = '0;
      dt        = '0;
      repeat (2) @(negedge clk);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_a_out", 64'(a_out), 64'd0);
      check("rst_flags", 64'({out_sat, out_err}), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // Normal, negative (with backpressure), overflow, bad dt.
      do_sample(32'h0001_0000, 32'h0000_8000, 0, 1'b0, ga);
      do_sample(32'h0003_0000, 32'h0000_8000, 0, 1'b0, ga);
      check("tp_normal", 64'(ga), 64'h0004_0000);
      do_sample(32'h0002_0000, 32'h0001_0000, 10, 1'b0, ga);
      check("tp_negative", 64'(ga), 64'hFFFF_0000);
      do_sample(32'h8000_0000, 32'h0000_0001, 0, 1'b1, ga);
      do_sample(32'h7FFF_FFFF, 32'h0000_0001, 0, 1'b0, ga);
`ifdef IMU_DIFF_SAT_EN
      check("tp_overflow", 64'(ga), 64'h7FFF_FFFF);
`else
      check("tp_overflow", 64'(ga), 64'hFFFF_0000);
`endif
      do_sample(32'h0005_0000, 32'h0000_0000, 2, 1'b0, ga);
      do_sample(32'h0007_0000, 32'h0001_0000, 0, 1'b0, ga);
      check("tp_after_bad_dt", 64'(ga), 64'h0002_0000);

      // Reset while dividing.
      in_valid = 1'b1;
      v_in     = 32'h0009_0000;
      dt       = 32'h0001_0000;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (19) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_a_out", 64'(a_out), 64'd0);
      check("mid_rst_flags", 64'({out_sat, out_err}), 64'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      m_primed = 1'b0;
      m_prev   = '0;
      @(negedge clk);
      check("mid_rst_in_ready", 64'(in_ready), 64'd1);
      do_sample(32'h0010_0000, 32'h0001_0000, 0, 1'b0, ga);
      do_sample(32'h000C_0000, 32'h0002_0000, 0, 1'b0, ga);
      check("post_rst_result", 64'(ga), 64'hFFFE_0000);

      // Randomized traffic.
      for (int k = 0; k < 40; k++) begin
         mode = int'($urandom_range(0, 9));
         if (mode == 0) begin
            rv = $urandom;
            rd = ($urandom_range(0, 1) == 0) ? 32'h0 : ($urandom | 32'h8000_0000);
         end else if (mode <= 3) begin
            rv = $urandom;
            rd = 32'($urandom_range(1, 255));
         end else begin
            rv = m_prev + 32'($signed($urandom_range(0, 32'h0008_0000)) - 32'sh0004_0000);
            rd = ($urandom & 32'h7FFF_FFFF) | 32'h0000_0100;
         end
         do_sample(rv, rd, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ga);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
